muldiv_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit for the RV32IM pipeline.

---
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: fixed-latency multiply, radix-2 restoring divide,
// start/busy/done handshake with flush and async active-low reset.
module muldiv_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            FLUSH,
  input  logic [2:0]      OP,
  input  logic [XLEN-1:0] OPERAND_A,
  input  logic [XLEN-1:0] OPERAND_B,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam int unsigned PW    = 2 * XLEN;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   quot_q, quot_d, rem_q, rem_d, dvs_q, dvs_d;
  logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic              busy_d, done_d;
  logic [XLEN-1:0]   result_d;

  logic              is_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic signed [XLEN:0] mul_a, mul_b;
  logic [PW-1:0]     prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     rem_sh, diff;

  // Operand classification for an accepted divide
  always_comb begin
    is_signed = ~OP[0];
    a_neg     = is_signed & OPERAND_A[XLEN-1];
    b_neg     = is_signed & OPERAND_B[XLEN-1];
    a_mag     = a_neg ? -OPERAND_A : OPERAND_A;
    b_mag     = b_neg ? -OPERAND_B : OPERAND_B;
    div_zero  = (OPERAND_B == '0);
    div_ovf   = is_signed && (OPERAND_A == {1'b1, {(XLEN-1){1'b0}}}) && (OPERAND_B == '1);
  end

  // Multiply datapath on latched operands; high half for MULH*, low half for MUL
  always_comb begin
    mul_a   = $signed({(op_q != 2'b11) & a_q[XLEN-1], a_q});
    mul_b   = $signed({~op_q[1] & b_q[XLEN-1], b_q});
    prod    = PW'(mul_a) * PW'(mul_b);
    mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
  end

  // One restoring-division step
  always_comb begin
    rem_sh = {rem_q, quot_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = RESULT;

    if (FLUSH) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (START) begin
            op_d  = OP[1:0];
            a_d   = OPERAND_A;
            b_d   = OPERAND_B;
            cnt_d = '0;
            if (!OP[2]) begin
              state_d = S_MUL;
            end else if (div_zero) begin
              // Special cases skip iteration and resolve in FIXUP with no sign change
              state_d   = S_FIXUP;
              quot_d    = '1;
              rem_d     = OPERAND_A;
              neg_quo_d = 1'b0;
              neg_rem_d = 1'b0;
            end else if (div_ovf) begin
              state_d   = S_FIXUP;
              quot_d    = OPERAND_A;
              rem_d     = '0;
              neg_quo_d = 1'b0;
              neg_rem_d = 1'b0;
            end else begin
              state_d   = S_DIV;
              quot_d    = a_mag;
              rem_d     = '0;
              dvs_d     = b_mag;
              neg_quo_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
            end
          end
        end
        S_MUL: begin
          if (cnt_q == CNT_W'(MUL_LATENCY - 1)) begin
            result_d = mul_res;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DIV: begin
          if (diff[XLEN]) begin
            rem_d  = rem_sh[XLEN-1:0];
            quot_d = {quot_q[XLEN-2:0], 1'b0};
          end else begin
            rem_d  = diff[XLEN-1:0];
            quot_d = {quot_q[XLEN-2:0], 1'b1};
          end
          if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_FIXUP;
          else                           cnt_d   = cnt_q + CNT_W'(1);
        end
        S_FIXUP: begin
          if (op_q[1]) result_d = neg_rem_q ? -rem_q : rem_q;
          else         result_d = neg_quo_q ? -quot_q : quot_q;
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIXUP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      RESULT    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      RESULT    <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32, MUL_LATENCY=1).
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  localparam int NV = 25;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic        FLUSH = 1'b0;
  logic [2:0]  OP = 3'b000;
  logic [31:0] OPERAND_A = '0;
  logic [31:0] OPERAND_B = '0;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int total = 0;
  int bad   = 0;
  vec_t vecs [NV];
  logic [31:0] last_exp;

  muldiv_unit #(.XLEN(32), .MUL_LATENCY(1)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FLUSH(FLUSH), .OP(OP),
    .OPERAND_A(OPERAND_A), .OPERAND_B(OPERAND_B),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  // Wait for DONE starting n edges after accept; returns edges counted and whether BUSY held
  task automatic wait_done(input int n0, output int n, output logic busy_ok);
    n = n0;
    busy_ok = 1'b1;
    while (!DONE && n < 100) begin
      if (!BUSY) busy_ok = 1'b0;
      @(posedge CLK); #1;
      n++;
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int   n;
    logic busy_ok;
    @(negedge CLK);
    START = 1'b1; OP = op; OPERAND_A = a; OPERAND_B = b;
    @(posedge CLK); #1;
    START = 1'b0; OP = 3'($urandom); OPERAND_A = $urandom; OPERAND_B = $urandom;
    wait_done(0, n, busy_ok);
    chk({nm, "_done"}, 32'(DONE), 32'd1);
    chk({nm, "_lat"}, 32'(n), 32'(lat));
    chk({nm, "_busy"}, {30'd0, busy_ok, BUSY}, 32'd2);
    chk({nm, "_res"}, RESULT, exp);
  endtask

  initial begin
    int   n;
    logic busy_ok;
    logic seen_done;

    vecs[0]  = '{"mul_neg",      OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1};
    vecs[1]  = '{"mulh_min",     OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1};
    vecs[2]  = '{"mulhsu_min",   OP_MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000, 1};
    vecs[3]  = '{"mulhu_min",    OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 1};
    vecs[4]  = '{"divu_100_7",   OP_DIVU,   32'd100,      32'd7,        32'd14,       33};
    vecs[5]  = '{"remu_100_7",   OP_REMU,   32'd100,      32'd7,        32'd2,        33};
    vecs[6]  = '{"div_m100_7",   OP_DIV,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33};
    vecs[7]  = '{"rem_m100_7",   OP_REM,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33};
    vecs[8]  = '{"div_by0",      OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{"remu_by0",     OP_REMU,   32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{"div_ovf",      OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{"rem_ovf",      OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{"mulhu_max",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1};
    vecs[13] = '{"mulh_m1",      OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1};
    vecs[14] = '{"mul_wrap",     OP_MUL,    32'h00010000, 32'h00010000, 32'd0,        1};
    vecs[15] = '{"div_100_m7",   OP_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33};
    vecs[16] = '{"rem_100_m7",   OP_REM,    32'd100,      32'hFFFFFFF9, 32'd2,        33};
    vecs[17] = '{"remu_max_10",  OP_REMU,   32'hFFFFFFFF, 32'd10,       32'd5,        33};
    vecs[18] = '{"divu_0_5",     OP_DIVU,   32'd0,        32'd5,        32'd0,        33};
    vecs[19] = '{"rem_m7_2",     OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[20] = '{"divu_by0",     OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[21] = '{"rem_min_by0",  OP_REM,    32'h80000000, 32'd0,        32'h80000000, 1};
    vecs[22] = '{"div_min_2",    OP_DIV,    32'h80000000, 32'd2,        32'hC0000000, 33};
    vecs[23] = '{"mulhsu_m1_2",  OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1};
    vecs[24] = '{"div_min_min",  OP_DIV,    32'h80000000, 32'h80000000, 32'd1,        33};

    #12;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_result", RESULT, 32'd0);
    @(negedge CLK); RESET = 1'b1;

    // Consecutive ops start during the previous DONE cycle (back-to-back accepts)
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end
    last_exp = vecs[NV-1].exp;

    // Flush at t0+10 of a DIVU
    @(negedge CLK);
    START = 1'b1; OP = OP_DIVU; OPERAND_A = 32'd1000; OPERAND_B = 32'd3;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK); FLUSH = 1'b1;
    @(posedge CLK); #1; FLUSH = 1'b0;
    chk("flush_busy", 32'(BUSY), 32'd0);
    chk("flush_done", 32'(DONE), 32'd0);
    chk("flush_result", RESULT, last_exp);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (DONE) seen_done = 1'b1;
    end
    chk("flush_no_done", 32'(seen_done), 32'd0);
    chk("flush_result_hold", RESULT, last_exp);

    // FLUSH and START together in IDLE: START dropped
    @(negedge CLK);
    START = 1'b1; FLUSH = 1'b1; OP = OP_MUL; OPERAND_A = 32'd3; OPERAND_B = 32'd3;
    @(posedge CLK); #1;
    START = 1'b0; FLUSH = 1'b0;
    chk("flush_beats_start_busy", 32'(BUSY), 32'd0);
    @(posedge CLK); #1;
    chk("flush_beats_start_done", 32'(DONE), 32'd0);
    chk("flush_beats_start_res", RESULT, last_exp);

    run_op("divu_9_2", OP_DIVU, 32'd9, 32'd2, 32'd4, 33);

    // START while BUSY is ignored
    @(negedge CLK);
    START = 1'b1; OP = OP_DIVU; OPERAND_A = 32'd20; OPERAND_B = 32'd3;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    START = 1'b1; OP = OP_MUL; OPERAND_A = 32'd2; OPERAND_B = 32'd3;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("busy_start_busy", 32'(BUSY), 32'd1);
    chk("busy_start_res", RESULT, 32'd4);
    wait_done(5, n, busy_ok);
    chk("busy_start_lat", 32'(n), 32'd33);
    chk("busy_start_q", RESULT, 32'd6);
    @(posedge CLK); #1;
    chk("busy_start_noqueue", {30'd0, BUSY, DONE}, 32'd0);

    // Asynchronous reset mid-divide
    @(negedge CLK);
    START = 1'b1; OP = OP_DIVU; OPERAND_A = 32'd100; OPERAND_B = 32'd7;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (5) @(posedge CLK);
    #2; RESET = 1'b0; #1;
    chk("arst_busy", 32'(BUSY), 32'd0);
    chk("arst_done", 32'(DONE), 32'd0);
    chk("arst_result", RESULT, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); RESET = 1'b1;
    run_op("post_rst_mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
    run_op("b2b_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
